axil_ram_ctrl: RTL and testbench

AXI4-Lite slave front end that sits directly upstream of the team's dual-port RAM (dp_ram) and drives its port-0 write/read controls. It accepts single-beat AXI4-Lite writes and reads and converts each into one RAM access. It returns the B response for writes, and captures the registered RAM read data for the R response. One transaction is in flight at a time; writes and reads are arbitrated round-robin.

---
 rtl/axil_ram_ctrl_if.sv | 38 +++
 rtl/axil_ram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_axil_ram_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_ctrl_if.sv
// AXI4-Lite slave bus bundle for the RAM controller front end.
// The master drives addresses, data and the response-ready strobes;
// the slave returns the address/data readies and the B/R responses.
interface axil_ram_ctrl_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int AXI_ADDR_WIDTH = 8
);
    logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
    logic                      s_awvalid;
    logic                      s_awready;
    logic [DATA_WIDTH-1:0]     s_wdata;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [1:0]                s_bresp;
    logic                      s_bvalid;
    logic                      s_bready;
    logic [AXI_ADDR_WIDTH-1:0] s_araddr;
    logic                      s_arvalid;
    logic                      s_arready;
    logic [DATA_WIDTH-1:0]     s_rdata;
    logic [1:0]                s_rresp;
    logic                      s_rvalid;
    logic                      s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_ram_ctrl.sv
// AXI4-Lite slave that turns single-beat writes and reads into one
// port-0 access of the dual-port RAM. One transaction in flight at a
// time; simultaneous write and read requests alternate round-robin.
// Out-of-range addresses skip the RAM and answer SLVERR.
module axil_ram_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4,
    parameter int DEPTH          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    axil_ram_ctrl_if.slave            s_axil,
    output logic                      ram_port_en,
    output logic                      ram_wr_en,
    output logic                      ram_rd_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_data_in,
    input  logic [DATA_WIDTH-1:0]     ram_data_out
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One extra bit so DEPTH itself is representable for the range check
    localparam logic [AXI_ADDR_WIDTH:0] LP_DEPTH = DEPTH[AXI_ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EXEC,
        ST_WR_RESP,
        ST_RD_EXEC,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_prio_rd;
    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                r_bresp;
    logic [1:0]                r_rresp;

    logic w_wr_req;
    logic w_rd_req;
    logic w_wr_err;
    logic w_rd_err;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_wr_req = s_axil.s_awvalid && s_axil.s_wvalid;
    assign w_rd_req = s_axil.s_arvalid;
    assign w_wr_err = ({1'b0, s_axil.s_awaddr} >= LP_DEPTH);
    assign w_rd_err = ({1'b0, s_axil.s_araddr} >= LP_DEPTH);

    assign s_axil.s_bresp = r_bresp;
    assign s_axil.s_rresp = r_rresp;
    assign s_axil.s_rdata = r_rdata;
    assign ram_addr       = r_addr;
    assign ram_data_in    = r_wdata;

    // State register; reset abandons any access or pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration, handshake readies, RAM strobes and next-state decode
    always_comb begin
        w_next_state      = r_state;
        w_grant_wr        = 1'b0;
        w_grant_rd        = 1'b0;
        s_axil.s_awready  = 1'b0;
        s_axil.s_wready   = 1'b0;
        s_axil.s_arready  = 1'b0;
        s_axil.s_bvalid   = 1'b0;
        s_axil.s_rvalid   = 1'b0;
        ram_port_en       = 1'b0;
        ram_wr_en         = 1'b0;
        ram_rd_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    if (w_wr_req && (!w_rd_req || !r_prio_rd)) begin
                        w_grant_wr       = 1'b1;
                        s_axil.s_awready = 1'b1;
                        s_axil.s_wready  = 1'b1;
                        w_next_state     = w_wr_err ? ST_WR_RESP : ST_WR_EXEC;
                    end else if (w_rd_req) begin
                        w_grant_rd       = 1'b1;
                        s_axil.s_arready = 1'b1;
                        w_next_state     = w_rd_err ? ST_RD_RESP : ST_RD_EXEC;
                    end
                end
            end
            ST_WR_EXEC: begin
                ram_port_en  = 1'b1;
                ram_wr_en    = 1'b1;
                w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                s_axil.s_bvalid = 1'b1;
                if (s_axil.s_bready) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_EXEC: begin
                ram_port_en  = 1'b1;
                ram_rd_en    = 1'b1;
                w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_next_state = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                s_axil.s_rvalid = 1'b1;
                if (s_axil.s_rready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch address/data/response at the grant, flip priority, capture RAM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_rd <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_grant_wr) begin
                r_prio_rd <= 1'b1;
                r_addr    <= s_axil.s_awaddr[RAM_ADDR_WIDTH-1:0];
                r_wdata   <= s_axil.s_wdata;
                r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_grant_rd) begin
                r_prio_rd <= 1'b0;
                r_addr    <= s_axil.s_araddr[RAM_ADDR_WIDTH-1:0];
                r_rdata   <= '0;
                r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_axil_ram_ctrl.sv
// Testbench for axil_ram_ctrl: directed cases followed by random traffic.
// Expected responses are queued when a transaction is issued; a monitor
// pops and compares them whenever a B or R handshake occurs.
module tb_axil_ram_ctrl;

    localparam int DATA_WIDTH     = 8;
    localparam int AXI_ADDR_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 4;
    localparam int DEPTH          = 16;

    typedef struct {
        bit         isWrite;
        logic [1:0] resp;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic                      ram_port_en;
    logic                      ram_wr_en;
    logic                      ram_rd_en;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_data_in;
    logic [DATA_WIDTH-1:0]     ram_data_out = '0;

    int testCount = 0;
    int failCount = 0;
    int wrStrobes = 0;
    int rdStrobes = 0;
    int expWrStrobes = 0;
    int expRdStrobes = 0;

    logic [7:0] ramMem [16];
    logic [7:0] refMem [16];
    bit         modelPrioWrite = 1'b1;
    exp_t       expQ [$];

    axil_ram_ctrl_if #(.DATA_WIDTH(DATA_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) bus ();

    axil_ram_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axil(bus),
        .ram_port_en(ram_port_en),
        .ram_wr_en(ram_wr_en),
        .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr),
        .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the dual-port RAM's port 0, counting every strobe cycle
    always @(posedge clk) begin
        if (ram_port_en && ram_wr_en) begin
            ramMem[ram_addr] <= ram_data_in;
            wrStrobes        <= wrStrobes + 1;
        end
        if (ram_port_en && ram_rd_en) begin
            ram_data_out <= ramMem[ram_addr];
            rdStrobes    <= rdStrobes + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: one transaction at a time, memory as a plain array
    task automatic modelIssue(input bit isWrite, input logic [7:0] addr, input logic [7:0] data, output exp_t e);
        bit ok;
        ok        = int'(addr) < DEPTH;
        e.isWrite = isWrite;
        e.resp    = ok ? 2'b00 : 2'b10;
        e.data    = 8'h00;
        if (isWrite && ok) begin
            refMem[addr[3:0]] = data;
            expWrStrobes++;
        end
        if (!isWrite && ok) begin
            e.data = refMem[addr[3:0]];
            expRdStrobes++;
        end
        modelPrioWrite = !isWrite;
        expQ.push_back(e);
    endtask

    task automatic modelReset();
        modelPrioWrite = 1'b1;
        expQ.delete();
    endtask

    function automatic bit granted(input bit isWrite);
        return isWrite ? (bus.s_awready && bus.s_wready) : bus.s_arready;
    endfunction

    function automatic bit respValid(input bit isWrite);
        return isWrite ? bus.s_bvalid : bus.s_rvalid;
    endfunction

    function automatic logic [63:0] allOutputs();
        return 64'({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp,
                    bus.s_arready, bus.s_rvalid, bus.s_rresp, bus.s_rdata,
                    ram_port_en, ram_wr_en, ram_rd_en, ram_addr, ram_data_in});
    endfunction

    task automatic clearValids();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_arvalid = 1'b0;
    endtask

    // Issue one transaction, check grant, RAM strobe, latency and response hold
    task automatic applyStimulus(input bit isWrite, input logic [7:0] addr, input logic [7:0] data, input int stall);
        exp_t e;
        bit   ok;
        bit   gotGrant;
        int   n;
        int   lat;
        int   expLat;
        ok     = int'(addr) < DEPTH;
        expLat = !ok ? 1 : (isWrite ? 2 : 3);
        modelIssue(isWrite, addr, data, e);
        @(posedge clk); #1;
        if (isWrite) begin
            bus.s_awaddr  = addr;
            bus.s_wdata   = data;
            bus.s_awvalid = 1'b1;
            bus.s_wvalid  = 1'b1;
        end else begin
            bus.s_araddr  = addr;
            bus.s_arvalid = 1'b1;
        end
        bus.s_bready = (stall == 0);
        bus.s_rready = (stall == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!granted(isWrite) && n < 20);
        gotGrant = granted(isWrite);
        checkOutput("grant", 64'(gotGrant), 64'(1));
        @(posedge clk); #1;
        clearValids();
        if (!gotGrant) return;
        @(negedge clk);
        if (ok) begin
            checkOutput("ram_strobe", 64'({ram_port_en, ram_wr_en, ram_rd_en}),
                        64'(isWrite ? 3'b110 : 3'b101));
            checkOutput("ram_addr", 64'(ram_addr), 64'(addr[3:0]));
            if (isWrite) checkOutput("ram_data_in", 64'(ram_data_in), 64'(data));
        end else begin
            checkOutput("no_strobe", 64'({ram_port_en, ram_wr_en, ram_rd_en}), 64'(0));
        end
        lat = 1;
        while (!respValid(isWrite) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(expLat));
        if (!respValid(isWrite)) return;
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (isWrite) begin
                    bus.s_araddr  = 8'h00;
                    bus.s_arvalid = 1'b1;
                end else begin
                    bus.s_awaddr  = 8'h00;
                    bus.s_wdata   = 8'h00;
                    bus.s_awvalid = 1'b1;
                    bus.s_wvalid  = 1'b1;
                end
                @(negedge clk);
                checkOutput("hold_valid", 64'(respValid(isWrite)), 64'(1));
                if (isWrite)
                    checkOutput("hold_bresp", 64'(bus.s_bresp), 64'(e.resp));
                else
                    checkOutput("hold_rresp_rdata", 64'({bus.s_rresp, bus.s_rdata}), 64'({e.resp, e.data}));
                checkOutput("no_grant", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'(0));
            end
            @(posedge clk); #1;
            clearValids();
            bus.s_bready = 1'b1;
            bus.s_rready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        bus.s_rready = 1'b0;
        @(negedge clk);
        checkOutput("valid_drop", 64'(respValid(isWrite)), 64'(0));
    endtask

    // Scoreboard monitor: compare each completed B/R beat with the oldest expectation
    always @(negedge clk) begin
        if (!rst && ((bus.s_bvalid && bus.s_bready) || (bus.s_rvalid && bus.s_rready))) begin
            checkOutput("resp_expected", 64'(expQ.size() > 0), 64'(1));
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                if (bus.s_bvalid && bus.s_bready) begin
                    checkOutput("b_kind", 64'(e.isWrite), 64'(1));
                    checkOutput("bresp", 64'(bus.s_bresp), 64'(e.resp));
                end else begin
                    checkOutput("r_kind", 64'(e.isWrite), 64'(0));
                    checkOutput("rresp", 64'(bus.s_rresp), 64'(e.resp));
                    checkOutput("rdata", 64'(bus.s_rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   wrLeft;
        int   rdLeft;
        bit   expectWrite;
        bit   sawWrite;

        for (int i = 0; i < 16; i++) begin
            ramMem[i] = 8'h00;
            refMem[i] = 8'h00;
        end
        bus.s_awaddr  = '0;
        bus.s_wdata   = '0;
        bus.s_araddr  = '0;
        bus.s_bready  = 1'b0;
        bus.s_rready  = 1'b0;
        clearValids();

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();

        // Directed: basic write/read and out-of-range accesses
        applyStimulus(1'b1, 8'd3, 8'hA5, 0);
        applyStimulus(1'b0, 8'd3, 8'h00, 0);
        applyStimulus(1'b1, 8'd20, 8'h77, 0);
        applyStimulus(1'b0, 8'd20, 8'h00, 0);

        // Directed: all requests held valid for four grants, round-robin order
        @(posedge clk); #1;
        bus.s_awaddr  = 8'd5;
        bus.s_wdata   = 8'h11;
        bus.s_araddr  = 8'd5;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid  = 1'b1;
        bus.s_arvalid = 1'b1;
        bus.s_bready  = 1'b1;
        bus.s_rready  = 1'b1;
        wrLeft = 2;
        rdLeft = 2;
        for (int k = 0; k < 4; k++) begin
            expectWrite = (wrLeft > 0) && ((rdLeft == 0) || modelPrioWrite);
            modelIssue(expectWrite, 8'd5, bus.s_wdata, e);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus.s_awready || bus.s_arready) && n < 20);
            sawWrite = bus.s_awready;
            checkOutput("grant_order", 64'(sawWrite), 64'(expectWrite));
            if (sawWrite) wrLeft--;
            else rdLeft--;
            @(posedge clk); #1;
            if (sawWrite) bus.s_wdata = 8'h22;
            if (wrLeft <= 0) begin
                bus.s_awvalid = 1'b0;
                bus.s_wvalid  = 1'b0;
            end
            if (rdLeft <= 0) bus.s_arvalid = 1'b0;
        end
        clearValids();
        n = 0;
        while (expQ.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("arb_drain", 64'(expQ.size()), 64'(0));
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        bus.s_rready = 1'b0;

        // Directed: B response back-pressured for five cycles
        applyStimulus(1'b1, 8'd9, 8'h3C, 5);
        applyStimulus(1'b0, 8'd9, 8'h00, 2);

        // Directed: reset while a read waits on RAM data
        modelIssue(1'b0, 8'd3, 8'h00, e);
        @(posedge clk); #1;
        bus.s_araddr  = 8'd3;
        bus.s_arvalid = 1'b1;
        bus.s_rready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_arready && n < 20);
        checkOutput("reset_test_grant", 64'(bus.s_arready), 64'(1));
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_mid_outputs", allOutputs(), 64'(0));
        modelReset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.s_rready = 1'b0;
        applyStimulus(1'b0, 8'd3, 8'h00, 0);

        // Random traffic with occasional out-of-range addresses and back-pressure
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 23)),
                          8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        n = 0;
        while (expQ.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("final_drain", 64'(expQ.size()), 64'(0));
        repeat (2) @(negedge clk);
        checkOutput("wr_strobe_count", 64'(wrStrobes), 64'(expWrStrobes));
        checkOutput("rd_strobe_count", 64'(rdStrobes), 64'(expRdStrobes));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
